instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter WIDTH, default 6: instruction word width in bits; legal range 1..32.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 loaderDone  input  1  program-load-complete qualifier; low blocks every write and read.
REQ-006 writeEnable  input  1  push dataIn into queue tail.
REQ-007 dataIn  input  WIDTH  instruction word to push.
REQ-008 readEnable  input  1  pop queue head (instruction consumed).
REQ-009 flush  input  1  discard all queued entries (branch/jump).
REQ-010 dataOut  output  WIDTH  registered current instruction (queue head, or last head when empty).
REQ-011 valid  output  1  queue non-empty; dataOut is a live head entry.
REQ-012 full  output  1  count equals DEPTH.
REQ-013 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-014 overflow  output  1  sticky: push attempted while full without simultaneous pop.

Function
REQ-015 Storage: circular buffer of DEPTH entries, head pointer, tail pointer, occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-016 Effective push = writeEnable & loaderDone & ~flush; effective pop = readEnable & loaderDone & ~flush & valid.
REQ-017 Pop when empty: ignored; no state change, no error flag.
REQ-018 Push when full without pop: entry dropped, pointers/count unchanged, overflow set to 1.
REQ-019 Push and pop same cycle, queue non-empty (including full): both performed, count unchanged, overflow not set.
REQ-020 Push and pop same cycle, queue empty: pop ignored, push performed, count becomes 1.
REQ-021 count = previous count + push - pop each edge; never exceeds DEPTH, never below 0.
REQ-022 dataOut after each edge: new head entry if queue non-empty after that edge; else holds its previous value.
REQ-023 Latency: push into empty queue at edge N gives dataOut = dataIn and valid = 1 after edge N (fall-through, zero extra cycles).
REQ-024 Pop at edge N with count >= 2: dataOut shows next entry after edge N; with count = 1: valid = 0 after edge N, dataOut unchanged.
REQ-025 flush: pointers and count cleared at the edge; valid = 0; dataOut holds; flush overrides same-cycle push and pop; overflow unaffected.
REQ-026 loaderDone low: queue contents, pointers, count, dataOut frozen; flush still acts.
REQ-027 valid, full derived from registered count; no combinational path from any input to any output.

Reset
REQ-028 reset high at edge: dataOut = 0, count = 0, valid = 0, full = 0, overflow = 0, pointers = 0; storage contents need not be cleared.
REQ-029 reset overrides flush, push and pop in the same cycle; reset mid-operation discards all entries.
REQ-030 overflow clears only on reset.

Structure
REQ-031 Shared package (processor_pkg): INSTR_WIDTH = 6, PREFETCH_DEPTH = 4 defaults; top-level instantiation uses these constants.
REQ-032 One sub-module, queue_ptr: parametrised wrapping pointer counter (increment, clear, synchronous reset), instantiated for head and tail.
REQ-033 Storage array inferred in-module as registers; no vendor primitives.

Verification
REQ-034 Reset, then loaderDone = 0, writeEnable = 1, dataIn = 6'h15 for 3 cycles -> count = 0, valid = 0, dataOut = 0.
REQ-035 loaderDone = 1, push 6'h01,6'h02,6'h03,6'h04 (DEPTH 4) -> full = 1, count = 4, dataOut = 6'h01 from first edge; push 6'h05 -> dropped, overflow = 1.
REQ-036 Full queue, push 6'h05 with pop same cycle -> count = 4, dataOut = 6'h02, overflow unchanged; 4 further pops -> dataOut 6'h03,6'h04,6'h05, then valid = 0 with dataOut = 6'h05.
REQ-037 Three entries queued, flush with writeEnable = 1 and readEnable = 1 -> count = 0, valid = 0, dataOut holds; next push 6'h2A -> dataOut = 6'h2A after one edge.
REQ-038 Push/pop 10 entries with interleaved pops to wrap pointers twice -> output order equals input order, count never exceeds 4.
REQ-039 Queue holding 2 entries, overflow = 1, reset asserted together with push -> all outputs at reset values next edge.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor constants and helpers for the instruction prefetch path.
package processor_pkg;

  localparam int unsigned INSTR_WIDTH    = 6;
  localparam int unsigned PREFETCH_DEPTH = 4;

  // Pointer width for a queue of the given depth (at least one bit).
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cntWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Handshake/data bundle between the instruction loader/fetch side and the prefetch queue.
interface instr_prefetch_queue_if
  import processor_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_WIDTH,
  parameter int unsigned DEPTH = PREFETCH_DEPTH
);

  localparam int unsigned CW = cntWidth(DEPTH);

  logic             loaderDone;
  logic             writeEnable;
  logic [WIDTH-1:0] dataIn;
  logic             readEnable;
  logic             flush;
  logic [WIDTH-1:0] dataOut;
  logic             valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;

  // Producer/consumer side driving the queue.
  modport master (
    output loaderDone, writeEnable, dataIn, readEnable, flush,
    input  dataOut, valid, full, count, overflow
  );

  // The queue itself.
  modport slave (
    input  loaderDone, writeEnable, dataIn, readEnable, flush,
    output dataOut, valid, full, count, overflow
  );

endinterface

// File: rtl/instr_prefetch_queue_ptr.sv
// Wrapping pointer counter used for the queue head and tail.
module queue_ptr
  import processor_pkg::*;
#(
  parameter int unsigned DEPTH = PREFETCH_DEPTH,
  localparam int unsigned PW   = ptrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Advance by one, wrapping DEPTH-1 -> 0; clear and reset return to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: circular buffer with fall-through registered head output.
module instr_prefetch_queue
  import processor_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_WIDTH,
  parameter int unsigned DEPTH = PREFETCH_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_prefetch_queue_if.slave bus
);

  localparam int unsigned PW = ptrWidth(DEPTH);
  localparam int unsigned CW = cntWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    countQ;
  logic [WIDTH-1:0] dataOutQ;
  logic             overflowQ;

  logic             validQ_c;
  logic             fullQ_c;
  logic             pushReq_c;
  logic             pop_c;
  logic             push_c;
  logic             dropPush_c;
  logic [PW-1:0]    headNext_c;

  // Status decoded from registered count only.
  assign validQ_c = (countQ != '0);
  assign fullQ_c  = (countQ == CW'(DEPTH));

  // Qualified push/pop; a push into a full queue lands only if a pop frees a slot.
  always_comb begin
    pushReq_c  = bus.writeEnable & bus.loaderDone & ~bus.flush;
    pop_c      = bus.readEnable & bus.loaderDone & ~bus.flush & validQ_c;
    push_c     = pushReq_c & (~fullQ_c | pop_c);
    dropPush_c = pushReq_c & fullQ_c & ~pop_c;
    headNext_c = (headPtr == PW'(DEPTH - 1)) ? '0 : headPtr + PW'(1);
  end

  queue_ptr #(.DEPTH(DEPTH)) uHeadPtr (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .inc   (pop_c),
    .ptr   (headPtr)
  );

  queue_ptr #(.DEPTH(DEPTH)) uTailPtr (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .inc   (push_c),
    .ptr   (tailPtr)
  );

  // Storage write at tail; contents are not reset.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem[tailPtr] <= bus.dataIn;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      countQ <= '0;
    end else if (bus.flush) begin
      countQ <= '0;
    end else begin
      countQ <= countQ + CW'(push_c) - CW'(pop_c);
    end
  end

  // Head register: load the entry that becomes head, bypassing storage when it is being written now.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOutQ <= '0;
    end else if (!bus.flush) begin
      if (pop_c) begin
        if (countQ >= CW'(2)) begin
          dataOutQ <= mem[headNext_c];
        end else if (push_c) begin
          dataOutQ <= bus.dataIn;
        end
      end else if (push_c && !validQ_c) begin
        dataOutQ <= bus.dataIn;
      end
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflowQ <= 1'b0;
    end else if (dropPush_c) begin
      overflowQ <= 1'b1;
    end
  end

  assign bus.dataOut  = dataOutQ;
  assign bus.valid    = validQ_c;
  assign bus.full     = fullQ_c;
  assign bus.count    = countQ;
  assign bus.overflow = overflowQ;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int unsigned W = 6;
  localparam int unsigned D = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   checkOn;

  instr_prefetch_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

  instr_prefetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0] mq[$];
  logic [W-1:0] mOut;
  logic         mOvf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply the queue rules to the inputs seen at each rising edge.
  always @(posedge clk) begin
    bit doPop;
    bit doPush;
    if (reset) begin
      mq.delete();
      mOut = '0;
      mOvf = 1'b0;
    end else if (bus.flush) begin
      mq.delete();
    end else if (bus.loaderDone) begin
      doPop  = bus.readEnable && (mq.size() > 0);
      doPush = bus.writeEnable;
      if (doPush && mq.size() == D && !doPop) begin
        doPush = 1'b0;
        mOvf   = 1'b1;
      end
      if (doPop) void'(mq.pop_front());
      if (doPush) mq.push_back(bus.dataIn);
      if (mq.size() > 0) mOut = mq[0];
    end
  end

  // Compare DUT against model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (checkOn) begin
      chk("m_dataOut",  32'(bus.dataOut),  32'(mOut));
      chk("m_valid",    32'(bus.valid),    32'(mq.size() > 0));
      chk("m_full",     32'(bus.full),     32'(mq.size() == D));
      chk("m_count",    32'(bus.count),    32'(mq.size()));
      chk("m_overflow", 32'(bus.overflow), 32'(mOvf));
    end
  end

  task automatic step(input bit ld, input bit we, input logic [W-1:0] din, input bit re, input bit fl);
    bus.loaderDone  = ld;
    bus.writeEnable = we;
    bus.dataIn      = din;
    bus.readEnable  = re;
    bus.flush       = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int popIdx;
    total = 0;
    bad   = 0;
    checkOn = 1'b0;
    reset = 1'b1;
    mOut = '0;
    mOvf = 1'b0;
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOn = 1'b1;
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_dataOut", 32'(bus.dataOut), 32'h00);
    reset = 1'b0;

    // Loader not done: pushes blocked.
    repeat (3) step(1'b0, 1'b1, 6'h15, 1'b0, 1'b0);
    chk("ld0_count", 32'(bus.count), 32'd0);
    chk("ld0_valid", 32'(bus.valid), 32'd0);
    chk("ld0_dataOut", 32'(bus.dataOut), 32'h00);

    // Fill to full, then overflow.
    step(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);
    chk("fill_first_dataOut", 32'(bus.dataOut), 32'h01);
    chk("fill_first_valid", 32'(bus.valid), 32'd1);
    step(1'b1, 1'b1, 6'h02, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h03, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h04, 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_ovf0", 32'(bus.overflow), 32'd0);
    step(1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_dataOut", 32'(bus.dataOut), 32'h01);

    // Push+pop while full.
    step(1'b1, 1'b1, 6'h05, 1'b1, 1'b0);
    chk("pp_full_count", 32'(bus.count), 32'd4);
    chk("pp_full_dataOut", 32'(bus.dataOut), 32'h02);
    chk("pp_full_ovf", 32'(bus.overflow), 32'd1);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("drain1", 32'(bus.dataOut), 32'h03);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("drain2", 32'(bus.dataOut), 32'h04);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("drain3", 32'(bus.dataOut), 32'h05);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("drain4_valid", 32'(bus.valid), 32'd0);
    chk("drain4_dataOut", 32'(bus.dataOut), 32'h05);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    chk("pop_empty_count", 32'(bus.count), 32'd0);

    // Flush overrides push and pop.
    step(1'b1, 1'b1, 6'h10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h12, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h3F, 1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.valid), 32'd0);
    chk("flush_dataOut", 32'(bus.dataOut), 32'h10);
    chk("flush_ovf", 32'(bus.overflow), 32'd1);
    step(1'b1, 1'b1, 6'h2A, 1'b0, 1'b0);
    chk("post_flush_dataOut", 32'(bus.dataOut), 32'h2A);
    chk("post_flush_count", 32'(bus.count), 32'd1);

    // Flush still acts with loader not done.
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    chk("ld0_flush_count", 32'(bus.count), 32'd0);
    chk("ld0_flush_dataOut", 32'(bus.dataOut), 32'h2A);

    // Streaming with interleaved pops, including push+pop at count 1.
    popIdx = 0;
    for (int i = 0; i < 13; i++) begin
      bit we;
      bit re;
      we = (i < 10);
      re = (i >= 10) || (i % 2 == 1) || (i >= 5);
      if (re && bus.valid) begin
        chk("order", 32'(bus.dataOut), 32'(6'h30 + 6'(popIdx)));
        popIdx++;
      end
      step(1'b1, we, 6'h30 + 6'(i), re, 1'b0);
      chk("count_le_depth", 32'(bus.count <= 3'(D)), 32'd1);
    end
    chk("stream_pops", 32'(popIdx), 32'd10);
    chk("stream_empty", 32'(bus.valid), 32'd0);
    chk("stream_last", 32'(bus.dataOut), 32'h39);

    // Reset mid-operation with a concurrent push.
    step(1'b1, 1'b1, 6'h21, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h22, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(bus.count), 32'd2);
    reset = 1'b1;
    step(1'b1, 1'b1, 6'h23, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rst_dataOut", 32'(bus.dataOut), 32'h00);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    step(1'b1, 1'b1, 6'h07, 1'b0, 1'b0);
    chk("after_rst_push", 32'(bus.dataOut), 32'h07);
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
